mem_access_unit: RTL
====================

Name: mem_access_unit

Overview:
- Memory-stage load/store unit.
- Consumes the memory control request that the execute stage issues (address, store data, size, sign, destination register) and performs the transaction on the data-memory port using a req/gnt/rvalid protocol.
- Load data is aligned and sign/zero-extended, then returned as a write-back result.
- Backpressure goes upstream through a ready signal. Misaligned accesses and a hung memory are reported as errors.

Parameters:
- TIMEOUT, 16: cycles to wait for dmem_gnt_i or dmem_rvalid_i before aborting; 0 disables the timeout.
- RD_W, 5: destination register index width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- req_valid_i  in  1  execute stage presents a memory op
- req_ready_o  out  1  unit can accept; high only in IDLE
- req_we_i  in  1  1=store, 0=load
- req_size_i  in  2  00 byte, 01 half, 10 word; 11 is illegal and treated as misaligned
- req_unsigned_i  in  1  zero-extend load (LBU/LHU)
- req_addr_i  in  32  byte address
- req_wdata_i  in  32  store data, LSB-justified
- req_rd_i  in  RD_W  load destination register
- dmem_req_o  out  1  memory request
- dmem_we_o  out  1  write enable
- dmem_be_o  out  4  byte enables
- dmem_addr_o  out  32  word address; bits [1:0] always 0
- dmem_wdata_o  out  32  lane-shifted store data
- dmem_gnt_i  in  1  request granted
- dmem_rvalid_i  in  1  read data valid
- dmem_rdata_i  in  32  read data word
- wb_valid_o  out  1  one-cycle pulse: load result valid
- wb_rd_o  out  RD_W  result register
- wb_data_o  out  32  extended load result
- st_done_o  out  1  one-cycle pulse: store granted
- misalign_o  out  1  one-cycle pulse: misaligned request rejected
- bus_err_o  out  1  one-cycle pulse: timeout abort
- busy_o  out  1  state != IDLE

Behaviour:
- Reset (rst low, async): state IDLE; all outputs 0 except req_ready_o=1; timeout counter 0; captured request cleared.
- Accept: req_valid_i && req_ready_o at a rising edge. Address, size, sign, we, rd and wdata are captured into registers. All memory-side outputs are driven from these registers only.
- Misalignment check at accept:
  - half with addr[0]=1, word with addr[1:0]!=0, or size 11.
  - Next cycle: misalign_o=1; state stays IDLE; no dmem_req_o.
- FSM (IDLE, REQ, RESP):
  - IDLE→REQ on an aligned accept. dmem_req_o=1 from the next cycle.
  - REQ: dmem_req_o, dmem_we_o, dmem_be_o, dmem_addr_o and dmem_wdata_o are held stable until dmem_gnt_i. On gnt: a store goes to IDLE with st_done_o=1 the following cycle; a load goes to RESP with dmem_req_o=0 the following cycle.
  - RESP: on dmem_rvalid_i, the result is registered. wb_valid_o, wb_rd_o and wb_data_o are valid the next cycle, and state returns to IDLE.
  - rvalid in the same cycle as gnt is not legal and is ignored. rvalid while in IDLE or REQ is ignored.
- Byte lanes, with off=addr[1:0]:
  - byte: be = 0001<<off.
  - half: be = 0011<<off.
  - word: be = 1111.
  - wdata = req_wdata_i << (8*off).
  - Load result = rdata >> (8*off), truncated to the access size. Sign-extended unless req_unsigned_i is set; a word load returns the data unmodified.
- Latency:
  - Aligned load: wb_valid_o appears 3 cycles after accept when gnt and rvalid each arrive in the first cycle they are possible (accept → REQ → RESP → wb).
  - Store: st_done_o appears 2 cycles after accept with immediate gnt.
- Back-to-back: req_ready_o rises in the cycle the result/done pulse is presented, so a new request can be accepted in that cycle.
- Timeout:
  - The counter resets on entering REQ or RESP and increments each cycle without the expected gnt/rvalid.
  - Reaching TIMEOUT: bus_err_o=1 for one cycle, dmem_req_o=0, return to IDLE, no wb_valid_o or st_done_o.
- Reset mid-transaction: state goes to IDLE immediately (async); dmem_req_o drops. Any late rvalid is ignored.
- wb_rd_o and wb_data_o hold their last values when wb_valid_o is low.

Decomposition:
- Shared core package:
  - mem_size_t enum (MEM_B, MEM_H, MEM_W).
  - lsu_state_t enum (LSU_IDLE, LSU_REQ, LSU_RESP).
  - Default for TIMEOUT.
- Sub-module lsu_align: purely combinational; computes the byte enables and store shift, and performs load extraction and extension. It is reused by the bench's reference model.

Test Plan:
- Aligned SW addr 0x104, data 0xDEADBEEF, gnt immediate → dmem_addr 0x104, be 1111, wdata 0xDEADBEEF; st_done_o 2 cycles after accept.
- LB addr 0x203, rdata 0x80FF_1234 → be 1000; wb_data 0xFFFFFF80, wb_rd preserved. The same access as LBU → 0x00000080.
- LH addr 0x302, rdata 0x8001_0000 with 3-cycle gnt delay → wb_data 0xFFFF8001 at cycle 3+3 after accept; dmem signals stable throughout REQ.
- LW addr 0x101 → misalign_o pulse next cycle; dmem_req_o never asserted; req_ready_o stays 1.
- Load with gnt but rvalid withheld, TIMEOUT=16 → bus_err_o pulse 16 cycles after entering RESP; a following SB at addr 0x001 (be 0010) completes normally.
- rst low while in REQ → dmem_req_o 0 asynchronously, busy_o 0. A stray rvalid after reset produces no wb_valid_o.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// -----------------------------------------------------------------------------
// mem_access_unit_pkg
// Shared types for the memory-stage load/store unit:
//   mem_size_t     - access size encoding as issued by the execute stage
//   lsu_state_t    - load/store unit transaction state
//   LSU_TIMEOUT_DEFAULT - default gnt/rvalid wait bound in cycles
//   lsu_misaligned - alignment check for a (size, addr[1:0]) pair
// -----------------------------------------------------------------------------
package mem_access_unit_pkg;

    typedef enum logic [1:0] {
        MEM_B = 2'b00,
        MEM_H = 2'b01,
        MEM_W = 2'b10
    } mem_size_t;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'b00,
        LSU_REQ  = 2'b01,
        LSU_RESP = 2'b10
    } lsu_state_t;

    localparam int LSU_TIMEOUT_DEFAULT = 16;

    // Size 2'b11 has no legal meaning and is rejected like a misaligned access.
    function automatic logic lsu_misaligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            MEM_B:   return 1'b0;
            MEM_H:   return off[0];
            MEM_W:   return (off != 2'b00);
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_lsu_align.sv
// -----------------------------------------------------------------------------
// lsu_align
// Purely combinational byte-lane logic for the load/store unit.
//   i_size     - access size (mem_size_t encoding)
//   i_off      - byte offset within the word (addr[1:0])
//   i_unsigned - zero-extend sub-word loads instead of sign-extending
//   i_wdata    - LSB-justified store data
//   i_rdata    - raw read word from memory
//   o_be       - byte enables for the access
//   o_wdata    - store data shifted onto its byte lanes
//   o_ldata    - load result, shifted down and extended to 32 bits
// -----------------------------------------------------------------------------
module lsu_align
    import mem_access_unit_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_off,
    input  logic        i_unsigned,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_ldata
);

    logic [4:0]  w_shamt;
    logic [31:0] w_rshift;

    assign w_shamt  = {i_off, 3'b000};
    assign o_wdata  = i_wdata << w_shamt;
    assign w_rshift = i_rdata >> w_shamt;

    always_comb begin
        o_be    = 4'b0000;
        o_ldata = w_rshift;
        case (i_size)
            MEM_B: begin
                o_be    = 4'b0001 << i_off;
                o_ldata = {{24{w_rshift[7] & ~i_unsigned}}, w_rshift[7:0]};
            end
            MEM_H: begin
                o_be    = 4'b0011 << i_off;
                o_ldata = {{16{w_rshift[15] & ~i_unsigned}}, w_rshift[15:0]};
            end
            MEM_W: begin
                o_be    = 4'b1111;
                o_ldata = w_rshift;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
// Memory-stage load/store unit. Accepts one request at a time from execute,
// runs it on a req/gnt/rvalid data-memory port and returns aligned, extended
// load data as a write-back result.
//   clk, rst             - clock, asynchronous active-low reset
//   req_*                - execute-stage request (valid/ready handshake)
//   dmem_*               - data-memory port; all outputs come from registers
//   wb_valid_o/rd/data   - load result (pulse), rd/data hold between results
//   st_done_o            - pulse when a store is granted
//   misalign_o           - pulse when a misaligned/illegal request is dropped
//   bus_err_o            - pulse when gnt or rvalid does not arrive in time
//   busy_o               - a transaction is in flight
// -----------------------------------------------------------------------------
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int TIMEOUT = LSU_TIMEOUT_DEFAULT,
    parameter int RD_W    = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic            req_we_i,
    input  logic [1:0]      req_size_i,
    input  logic            req_unsigned_i,
    input  logic [31:0]     req_addr_i,
    input  logic [31:0]     req_wdata_i,
    input  logic [RD_W-1:0] req_rd_i,
    output logic            dmem_req_o,
    output logic            dmem_we_o,
    output logic [3:0]      dmem_be_o,
    output logic [31:0]     dmem_addr_o,
    output logic [31:0]     dmem_wdata_o,
    input  logic            dmem_gnt_i,
    input  logic            dmem_rvalid_i,
    input  logic [31:0]     dmem_rdata_i,
    output logic            wb_valid_o,
    output logic [RD_W-1:0] wb_rd_o,
    output logic [31:0]     wb_data_o,
    output logic            st_done_o,
    output logic            misalign_o,
    output logic            bus_err_o,
    output logic            busy_o
);

    localparam int              CNT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    lsu_state_t      r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]     r_addr;
    logic [31:0]     r_wdata;
    logic [1:0]      r_size;
    logic            r_unsigned;
    logic            r_we;
    logic [RD_W-1:0] r_rd;
    logic            r_dmem_req;
    logic            r_wb_valid;
    logic [RD_W-1:0] r_wb_rd;
    logic [31:0]     r_wb_data;
    logic            r_st_done;
    logic            r_misalign;
    logic            r_bus_err;

    logic [3:0]      w_be;
    logic [31:0]     w_wdata;
    logic [31:0]     w_ldata;
    logic            w_timeout;

    // Lane logic works on the captured request so the memory side never sees
    // upstream inputs changing after the accept.
    lsu_align u_align (
        .i_size     (r_size),
        .i_off      (r_addr[1:0]),
        .i_unsigned (r_unsigned),
        .i_wdata    (r_wdata),
        .i_rdata    (dmem_rdata_i),
        .o_be       (w_be),
        .o_wdata    (w_wdata),
        .o_ldata    (w_ldata)
    );

    // TIMEOUT of 0 disables the abort entirely.
    assign w_timeout = (TIMEOUT != 0) && (r_cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= LSU_IDLE;
            r_cnt      <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_size     <= '0;
            r_unsigned <= 1'b0;
            r_we       <= 1'b0;
            r_rd       <= '0;
            r_dmem_req <= 1'b0;
            r_wb_valid <= 1'b0;
            r_wb_rd    <= '0;
            r_wb_data  <= '0;
            r_st_done  <= 1'b0;
            r_misalign <= 1'b0;
            r_bus_err  <= 1'b0;
        end else begin
            r_wb_valid <= 1'b0;
            r_st_done  <= 1'b0;
            r_misalign <= 1'b0;
            r_bus_err  <= 1'b0;
            case (r_state)
                LSU_IDLE: begin
                    if (req_valid_i) begin
                        r_addr     <= req_addr_i;
                        r_wdata    <= req_wdata_i;
                        r_size     <= req_size_i;
                        r_unsigned <= req_unsigned_i;
                        r_we       <= req_we_i;
                        r_rd       <= req_rd_i;
                        if (lsu_misaligned(req_size_i, req_addr_i[1:0])) begin
                            r_misalign <= 1'b1;
                        end else begin
                            r_state    <= LSU_REQ;
                            r_dmem_req <= 1'b1;
                            r_cnt      <= '0;
                        end
                    end
                end
                LSU_REQ: begin
                    // rvalid is not expected before the grant and is ignored here.
                    if (dmem_gnt_i) begin
                        r_dmem_req <= 1'b0;
                        r_cnt      <= '0;
                        if (r_we) begin
                            r_st_done <= 1'b1;
                            r_state   <= LSU_IDLE;
                        end else begin
                            r_state   <= LSU_RESP;
                        end
                    end else if (w_timeout) begin
                        r_dmem_req <= 1'b0;
                        r_bus_err  <= 1'b1;
                        r_state    <= LSU_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                LSU_RESP: begin
                    if (dmem_rvalid_i) begin
                        r_wb_valid <= 1'b1;
                        r_wb_rd    <= r_rd;
                        r_wb_data  <= w_ldata;
                        r_state    <= LSU_IDLE;
                    end else if (w_timeout) begin
                        r_bus_err <= 1'b1;
                        r_state   <= LSU_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= LSU_IDLE;
            endcase
        end
    end

    assign req_ready_o  = (r_state == LSU_IDLE);
    assign busy_o       = (r_state != LSU_IDLE);
    assign dmem_req_o   = r_dmem_req;
    assign dmem_we_o    = r_dmem_req & r_we;
    assign dmem_be_o    = r_dmem_req ? w_be : 4'b0000;
    assign dmem_addr_o  = {r_addr[31:2], 2'b00};
    assign dmem_wdata_o = w_wdata;
    assign wb_valid_o   = r_wb_valid;
    assign wb_rd_o      = r_wb_rd;
    assign wb_data_o    = r_wb_data;
    assign st_done_o    = r_st_done;
    assign misalign_o   = r_misalign;
    assign bus_err_o    = r_bus_err;

endmodule
